// File: rtl/div_meter_pkg.sv
// rtl/div_meter_pkg.sv - shared constants and state encoding for the divided-clock period meter
package div_meter_pkg;

   localparam int DEF_CNT_W = 16;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE    = 1'b0;
   localparam state_t ST_MEASURE = 1'b1;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - 2-FF synchronizer with registered level and rise/fall pulses
module sync_edge_det (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sig,
   output logic sig_sync,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync_q;
   logic edge_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         meta   <= 1'b0;
         sync_q <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         meta   <= i_sig;
         sync_q <= meta;
         edge_q <= sync_q;
      end
   end

   assign sig_sync = sync_q;
   assign rise     = sync_q & ~edge_q;
   assign fall     = ~sync_q & edge_q;

endmodule

// File: rtl/div_clk_meter.sv
// rtl/div_clk_meter.sv - measures period (and high time with DIV_METER_DUTY_EN) of an async divided clock
module div_clk_meter
   import div_meter_pkg::*;
#(
   parameter int          CNT_W      = DEF_CNT_W,
   parameter int unsigned MAX_PERIOD = (2 ** CNT_W) - 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_sig,
   output logic [CNT_W-1:0] o_period,
   output logic [CNT_W-1:0] o_high,
   output logic             o_valid,
   output logic             o_locked,
   output logic             o_timeout
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic             sig_sync;
   logic             rise;
   logic             fall;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             have_prev;
   logic             unused_sig;

   sync_edge_det u_sync (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_sig    (i_sig),
      .sig_sync (sig_sync),
      .rise     (rise),
      .fall     (fall)
   );

   assign unused_sig = ^{fall, sig_sync};

   // A rise on the cycle cnt reaches MAX_CNT is a valid period, not a timeout.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         have_prev <= 1'b0;
         o_period  <= '0;
         o_valid   <= 1'b0;
         o_locked  <= 1'b0;
         o_timeout <= 1'b0;
      end else begin
         o_valid   <= 1'b0;
         o_timeout <= 1'b0;
         if (state == ST_IDLE) begin
            have_prev <= 1'b0;
            if (rise) begin
               cnt   <= ONE;
               state <= ST_MEASURE;
            end
         end else begin
            if (rise) begin
               o_period  <= cnt;
               o_valid   <= 1'b1;
               o_locked  <= have_prev && (cnt == o_period);
               have_prev <= 1'b1;
               cnt       <= ONE;
            end else if (cnt == MAX_CNT) begin
               o_timeout <= 1'b1;
               o_locked  <= 1'b0;
               have_prev <= 1'b0;
               state     <= ST_IDLE;
            end else begin
               cnt <= cnt + ONE;
            end
         end
      end
   end

`ifdef DIV_METER_DUTY_EN
   logic [CNT_W-1:0] hcnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hcnt   <= '0;
         o_high <= '0;
      end else if (rise) begin
         if (state == ST_MEASURE) begin
            o_high <= hcnt;
         end
         hcnt <= ONE;
      end else if (state == ST_MEASURE && sig_sync && hcnt != MAX_CNT) begin
         hcnt <= hcnt + ONE;
      end
   end
`else
   assign o_high = '0;
`endif

endmodule

// File: tb/tb_div_clk_meter.sv
// tb/tb_div_clk_meter.sv - directed self-checking bench for div_clk_meter
module tb_div_clk_meter;

   localparam int CNT_W = 16;
   localparam int MAXP  = 20;
`ifdef DIV_METER_DUTY_EN
   localparam bit HI_ON = 1'b1;
`else
   localparam bit HI_ON = 1'b0;
`endif

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic             i_sig;
   logic [CNT_W-1:0] o_period;
   logic [CNT_W-1:0] o_high;
   logic             o_valid;
   logic             o_locked;
   logic             o_timeout;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int vcnt   = 0;
   int tcnt   = 0;
   int both   = 0;
   int lv_cyc = 0;
   int to_cyc = 0;
   logic [CNT_W-1:0] lv_period;
   logic [CNT_W-1:0] lv_high;
   logic             lv_locked;

   div_clk_meter #(.CNT_W(CNT_W), .MAX_PERIOD(MAXP)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_sig     (i_sig),
      .o_period  (o_period),
      .o_high    (o_high),
      .o_valid   (o_valid),
      .o_locked  (o_locked),
      .o_timeout (o_timeout)
   );

   always #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
      cyc++;
      if (o_valid) begin
         vcnt++;
         lv_period = o_period;
         lv_high   = o_high;
         lv_locked = o_locked;
         lv_cyc    = cyc;
      end
      if (o_timeout) begin
         tcnt++;
         to_cyc = cyc;
         if (o_valid) both++;
      end
   endtask

   task automatic run_periods(input int h, input int l, input int n);
      for (int p = 0; p < n; p++) begin
         i_sig = 1'b1;
         repeat (h) step();
         i_sig = 1'b0;
         repeat (l) step();
      end
   endtask

   function automatic logic [CNT_W-1:0] exp_high(input int h);
      return HI_ON ? CNT_W'(h) : '0;
   endfunction

   task automatic test_reset();
      i_rst = 1'b1;
      i_sig = 1'b0;
      for (int i = 0; i < 2; i++) begin
         i_sig = ~i_sig;
         step();
         checks++;
         if ({o_period, o_high, o_valid, o_locked, o_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs cycle %0d: period=%0d high=%0d valid=%b locked=%b timeout=%b, required all 0", i, o_period, o_high, o_valid, o_locked, o_timeout);
         end
      end
      i_sig = 1'b0;
      i_rst = 1'b0;
      vcnt = 0; tcnt = 0;
      repeat (5) step();
      checks++;
      if (vcnt !== 0) begin
         errors++;
         $display("FAIL reset_no_valid: got %0d valids, required 0", vcnt);
      end
   endtask

   task automatic test_div7();
      vcnt = 0;
      run_periods(3, 4, 1);
      checks++;
      if (vcnt !== 0) begin
         errors++;
         $display("FAIL div7_first_rise: got %0d valids, required 0", vcnt);
      end
      run_periods(3, 4, 1);
      checks++;
      if (vcnt !== 1 || lv_period !== 16'd7 || lv_locked !== 1'b0) begin
         errors++;
         $display("FAIL div7_second_rise: valids=%0d period=%0d locked=%b, required 1/7/0", vcnt, lv_period, lv_locked);
      end
      checks++;
      if (lv_high !== exp_high(3)) begin
         errors++;
         $display("FAIL div7_high: got %0d, required %0d", lv_high, exp_high(3));
      end
      run_periods(3, 4, 1);
      checks++;
      if (vcnt !== 2 || lv_period !== 16'd7 || lv_locked !== 1'b1) begin
         errors++;
         $display("FAIL div7_lock: valids=%0d period=%0d locked=%b, required 2/7/1", vcnt, lv_period, lv_locked);
      end
      run_periods(3, 4, 2);
      checks++;
      if (vcnt !== 4 || lv_period !== 16'd7 || lv_locked !== 1'b1) begin
         errors++;
         $display("FAIL div7_steady: valids=%0d period=%0d locked=%b, required 4/7/1", vcnt, lv_period, lv_locked);
      end
   endtask

   task automatic test_switch_div5();
      vcnt = 0;
      run_periods(2, 3, 1);
      checks++;
      if (vcnt !== 1 || lv_period !== 16'd7 || lv_locked !== 1'b1) begin
         errors++;
         $display("FAIL div5_tail7: valids=%0d period=%0d locked=%b, required 1/7/1", vcnt, lv_period, lv_locked);
      end
      run_periods(2, 3, 1);
      checks++;
      if (vcnt !== 2 || lv_period !== 16'd5 || lv_locked !== 1'b0) begin
         errors++;
         $display("FAIL div5_first: valids=%0d period=%0d locked=%b, required 2/5/0", vcnt, lv_period, lv_locked);
      end
      checks++;
      if (lv_high !== exp_high(2)) begin
         errors++;
         $display("FAIL div5_high: got %0d, required %0d", lv_high, exp_high(2));
      end
      run_periods(2, 3, 1);
      checks++;
      if (vcnt !== 3 || lv_period !== 16'd5 || lv_locked !== 1'b1) begin
         errors++;
         $display("FAIL div5_relock: valids=%0d period=%0d locked=%b, required 3/5/1", vcnt, lv_period, lv_locked);
      end
   endtask

   task automatic test_timeout();
      vcnt = 0; tcnt = 0;
      i_sig = 1'b0;
      repeat (30) step();
      checks++;
      if (tcnt !== 1 || vcnt !== 0) begin
         errors++;
         $display("FAIL timeout_pulse: timeout cycles=%0d valids=%0d, required 1/0", tcnt, vcnt);
      end
      checks++;
      if (to_cyc - lv_cyc !== MAXP) begin
         errors++;
         $display("FAIL timeout_delay: got %0d cycles after last valid, required %0d", to_cyc - lv_cyc, MAXP);
      end
      checks++;
      if (o_locked !== 1'b0 || o_period !== 16'd5 || o_timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_hold: locked=%b period=%0d timeout=%b, required 0/5/0", o_locked, o_period, o_timeout);
      end
      run_periods(2, 3, 1);
      checks++;
      if (vcnt !== 0) begin
         errors++;
         $display("FAIL restart_first_rise: got %0d valids, required 0", vcnt);
      end
      run_periods(2, 3, 1);
      checks++;
      if (vcnt !== 1 || lv_period !== 16'd5 || lv_locked !== 1'b0) begin
         errors++;
         $display("FAIL restart_second_rise: valids=%0d period=%0d locked=%b, required 1/5/0", vcnt, lv_period, lv_locked);
      end
   endtask

   task automatic test_mid_reset();
      run_periods(2, 3, 2);
      checks++;
      if (o_locked !== 1'b1) begin
         errors++;
         $display("FAIL midrst_prelock: locked=%b, required 1", o_locked);
      end
      i_sig = 1'b1;
      repeat (2) step();
      i_sig = 1'b0;
      step();
      i_rst = 1'b1;
      vcnt = 0;
      step();
      checks++;
      if ({o_period, o_high, o_valid, o_locked, o_timeout} !== '0) begin
         errors++;
         $display("FAIL midrst_outputs: period=%0d high=%0d valid=%b locked=%b timeout=%b, required all 0", o_period, o_high, o_valid, o_locked, o_timeout);
      end
      i_rst = 1'b0;
      repeat (2) step();
      run_periods(2, 3, 1);
      checks++;
      if (vcnt !== 0) begin
         errors++;
         $display("FAIL midrst_no_partial: got %0d valids, required 0", vcnt);
      end
      run_periods(2, 3, 1);
      checks++;
      if (vcnt !== 1 || lv_period !== 16'd5 || lv_locked !== 1'b0) begin
         errors++;
         $display("FAIL midrst_resume: valids=%0d period=%0d locked=%b, required 1/5/0", vcnt, lv_period, lv_locked);
      end
   endtask

   task automatic test_max_period();
      i_rst = 1'b1;
      i_sig = 1'b0;
      repeat (2) step();
      i_rst = 1'b0;
      vcnt = 0; tcnt = 0;
      run_periods(1, MAXP - 1, 4);
      checks++;
      if (vcnt !== 3 || tcnt !== 0) begin
         errors++;
         $display("FAIL max_counts: valids=%0d timeouts=%0d, required 3/0", vcnt, tcnt);
      end
      checks++;
      if (lv_period !== 16'(MAXP) || lv_locked !== 1'b1 || lv_high !== exp_high(1)) begin
         errors++;
         $display("FAIL max_values: period=%0d locked=%b high=%0d, required %0d/1/%0d", lv_period, lv_locked, lv_high, MAXP, exp_high(1));
      end
      checks++;
      if (both !== 0) begin
         errors++;
         $display("FAIL valid_timeout_overlap: got %0d cycles with both, required 0", both);
      end
   endtask

   initial begin
      i_rst = 1'b1;
      i_sig = 1'b0;
      test_reset();
      test_div7();
      test_switch_div5();
      test_timeout();
      test_mid_reset();
      test_max_period();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
